// File: rtl/reu_ram_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake expansion-RAM port between
// the DMA engine (port 0) and the host/loader (port 1), one transaction in flight.
module reu_ram_arbiter #(
    parameter int ram_a_bits = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ram_a_bits-1:0] c0_a,
    input  logic [7:0]            c0_d,
    input  logic                  c0_we,
    input  logic                  c0_req,
    output logic [7:0]            c0_q,
    output logic                  c0_ack,
    input  logic [ram_a_bits-1:0] c1_a,
    input  logic [7:0]            c1_d,
    input  logic                  c1_we,
    input  logic                  c1_req,
    output logic [7:0]            c1_q,
    output logic                  c1_ack,
    output logic [ram_a_bits-1:0] ram_a,
    output logic [7:0]            ram_d,
    output logic                  ram_we,
    output logic                  ram_req,
    input  logic [7:0]            ram_q,
    input  logic                  ram_ack,
    output logic                  grant,
    output logic                  busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state;
    logic   last;
    logic   p0;
    logic   p1;
    logic   sel;

    // Only meaningful when at least one port is pending; ties go to the port
    // that did not own the previous transaction.
    function automatic logic pick(input logic pend0, input logic pend1, input logic prev);
        if (pend0 && pend1)
            return ~prev;
        return ~pend0;
    endfunction

    always_comb begin
        p0  = c0_req ^ c0_ack;
        p1  = c1_req ^ c1_ack;
        sel = pick(p0, p1, last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            ram_a   <= '0;
            ram_d   <= '0;
            ram_we  <= 1'b0;
            ram_req <= 1'b0;
            c0_ack  <= 1'b0;
            c1_ack  <= 1'b0;
            c0_q    <= '0;
            c1_q    <= '0;
            grant   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0 || p1) begin
                        if (sel) begin
                            ram_a  <= c1_a;
                            ram_d  <= c1_d;
                            ram_we <= c1_we;
                        end else begin
                            ram_a  <= c0_a;
                            ram_d  <= c0_d;
                            ram_we <= c0_we;
                        end
                        ram_req <= ~ram_req;
                        grant   <= sel;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // q is returned for writes as well as reads
                    if (ram_ack == ram_req) begin
                        if (grant) begin
                            c1_q   <= ram_q;
                            c1_ack <= ~c1_ack;
                        end else begin
                            c0_q   <= ram_q;
                            c0_ack <= ~c0_ack;
                        end
                        last  <= grant;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reu_ram_arbiter.sv
// Bench for reu_ram_arbiter: toggle-handshake RAM model, directed corner cases,
// a table of single transactions and a randomized two-port run with a reference model.
module tb_reu_ram_arbiter;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] c0_a = '0, c1_a = '0;
    logic [7:0]    c0_d = '0, c1_d = '0;
    logic          c0_we = 1'b0, c1_we = 1'b0;
    logic          c0_req = 1'b0, c1_req = 1'b0;
    logic [7:0]    c0_q, c1_q;
    logic          c0_ack, c1_ack;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic          ram_we, ram_req;
    logic [7:0]    ram_q;
    logic          ram_ack;
    logic          grant, busy;

    reu_ram_arbiter #(.ram_a_bits(AW)) dut (
        .clk(clk), .reset(reset),
        .c0_a(c0_a), .c0_d(c0_d), .c0_we(c0_we), .c0_req(c0_req), .c0_q(c0_q), .c0_ack(c0_ack),
        .c1_a(c1_a), .c1_d(c1_d), .c1_we(c1_we), .c1_req(c1_req), .c1_q(c1_q), .c1_ack(c1_ack),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_req(ram_req),
        .ram_q(ram_q), .ram_ack(ram_ack), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM controller model: write returns the written byte as q
    logic [7:0] mem [logic [AW-1:0]];
    int         lat = 3;
    bit         rand_lat = 1'b0;
    bit         active;
    int         cnt;

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ack <= 1'b0;
            ram_q   <= '0;
            active  <= 1'b0;
            cnt     <= 0;
        end else if (!active) begin
            if (ram_req != ram_ack) begin
                active <= 1'b1;
                cnt    <= rand_lat ? int'($urandom_range(1, 4)) : lat;
            end
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else begin
            active  <= 1'b0;
            ram_ack <= ~ram_ack;
            if (ram_we) begin
                mem[ram_a] = ram_d;
                ram_q <= ram_d;
            end else begin
                ram_q <= mem.exists(ram_a) ? mem[ram_a] : init_val(ram_a);
            end
        end
    end

    typedef struct {
        logic          g;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic          we;
        int            cyc;
    } iss_t;

    iss_t iss[$];
    int   ack_cyc[2];

    function automatic logic get_req(input int p);
        return (p == 0) ? c0_req : c1_req;
    endfunction
    function automatic logic get_ack(input int p);
        return (p == 0) ? c0_ack : c1_ack;
    endfunction
    function automatic logic [7:0] get_q(input int p);
        return (p == 0) ? c0_q : c1_q;
    endfunction

    task automatic issue_req(input int p, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        if (p == 0) begin
            c0_we = we; c0_a = a; c0_d = d; c0_req = ~c0_req;
        end else begin
            c1_we = we; c1_a = a; c1_d = d; c1_req = ~c1_req;
        end
    endtask

    task automatic run_until_idle(input int budget);
        logic pr, pa0, pa1;
        int   n;
        pr  = ram_req;
        pa0 = c0_ack;
        pa1 = c1_ack;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ram_req != pr) begin
                iss.push_back('{grant, ram_a, ram_d, ram_we, cyc});
                pr = ram_req;
            end
            if (c0_ack != pa0) begin ack_cyc[0] = cyc; pa0 = c0_ack; end
            if (c1_ack != pa1) begin ack_cyc[1] = cyc; pa1 = c1_ack; end
            if (c0_ack == c0_req && c1_ack == c1_req && !busy) break;
        end
        chk("idle_reached", 32'(n < budget), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_a"},   32'(ram_a),   32'd0);
        chk({tag, "_ram_d"},   32'(ram_d),   32'd0);
        chk({tag, "_ram_we"},  32'(ram_we),  32'd0);
        chk({tag, "_ram_req"}, 32'(ram_req), 32'd0);
        chk({tag, "_c0_ack"},  32'(c0_ack),  32'd0);
        chk({tag, "_c1_ack"},  32'(c1_ack),  32'd0);
        chk({tag, "_c0_q"},    32'(c0_q),    32'd0);
        chk({tag, "_c1_q"},    32'(c1_q),    32'd0);
        chk({tag, "_grant"},   32'(grant),   32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    // Requesters share the arbiter reset, so their req toggles restart at 0
    task automatic pulse_reset_midcycle(input string tag);
        @(posedge clk);
        #3;
        reset  = 1'b1;
        c0_req = 1'b0;
        c1_req = 1'b0;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    exp_q;
    } vec_t;

    vec_t vt[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            n0, n1, ok;
        logic          pr;
        logic [7:0]    exp_q[2];
        logic [7:0]    ref_mem [logic [AW-1:0]];
        int            sent[2];
        bit            pend[2];
        int            wait_cnt[2];
        logic          pa[2];
        logic [AW-1:0] ra;
        logic [7:0]    rd;
        logic          rwe;
        int            g;

        vt[0] = '{0, 1'b1, 17'h00100, 8'h3C, 8'h3C};
        vt[1] = '{1, 1'b0, 17'h00100, 8'h00, 8'h3C};
        vt[2] = '{1, 1'b1, 17'h1FFFF, 8'hC3, 8'hC3};
        vt[3] = '{0, 1'b0, 17'h1FFFF, 8'h00, 8'hC3};
        vt[4] = '{0, 1'b1, 17'h00000, 8'hFF, 8'hFF};
        vt[5] = '{1, 1'b0, 17'h00000, 8'h00, 8'hFF};
        mem[17'h1F123] = 8'hA5;

        // reset asserted between clock edges acts immediately
        #1 reset = 1'b1;
        #1 chk_all_zero("rst0");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (ram_req !== 1'b0) ok = 0;
        end
        chk("idle_no_req", 32'(ok), 32'd1);

        // port 0 read
        lat = 3;
        @(negedge clk);
        issue_req(0, 1'b0, 17'h1F123, 8'h00);
        @(negedge clk);
        chk("rd_ram_req", 32'(ram_req), 32'd1);
        chk("rd_ram_a", 32'(ram_a), 32'h1F123);
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_grant", 32'(grant), 32'd0);
        run_until_idle(50);
        chk("rd_c0_q", 32'(c0_q), 32'hA5);
        chk("rd_c0_ack", 32'(c0_ack), 32'(c0_req));
        chk("rd_c1_ack", 32'(c1_ack), 32'd0);
        chk("rd_c1_q", 32'(c1_q), 32'd0);

        pulse_reset_midcycle("rst1");

        // simultaneous writes
        iss.delete();
        @(negedge clk);
        issue_req(0, 1'b1, 17'h00010, 8'h11);
        issue_req(1, 1'b1, 17'h00020, 8'h22);
        run_until_idle(100);
        chk("sim_count", 32'(iss.size()), 32'd2);
        if (iss.size() == 2) begin
            chk("sim_g0", 32'(iss[0].g), 32'd0);
            chk("sim_d0", 32'(iss[0].d), 32'h11);
            chk("sim_a0", 32'(iss[0].a), 32'h00010);
            chk("sim_g1", 32'(iss[1].g), 32'd1);
            chk("sim_d1", 32'(iss[1].d), 32'h22);
            chk("sim_a1", 32'(iss[1].a), 32'h00020);
        end
        chk("sim_c0_q", 32'(c0_q), 32'h11);
        chk("sim_c1_q", 32'(c1_q), 32'h22);

        // saturation: both ports re-request right after each ack
        iss.delete();
        @(negedge clk);
        issue_req(0, 1'b1, 17'h00200, 8'h40);
        issue_req(1, 1'b1, 17'h00300, 8'h80);
        n0 = 1;
        n1 = 1;
        pr = ram_req;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (ram_req != pr) begin
                iss.push_back('{grant, ram_a, ram_d, ram_we, cyc});
                pr = ram_req;
            end
            if (c0_ack == c0_req && n0 < 8) begin
                issue_req(0, 1'b1, 17'h00200 + 17'(n0), 8'h40 + 8'(n0));
                n0++;
            end
            if (c1_ack == c1_req && n1 < 8) begin
                issue_req(1, 1'b1, 17'h00300 + 17'(n1), 8'h80 + 8'(n1));
                n1++;
            end
            if (n0 == 8 && n1 == 8 && c0_ack == c0_req && c1_ack == c1_req && !busy) begin
                ok = 1;
                break;
            end
        end
        chk("sat_done", 32'(ok), 32'd1);
        chk("sat_count", 32'(iss.size()), 32'd16);
        for (int i = 0; i < iss.size(); i++)
            chk($sformatf("sat_grant%0d", i), 32'(iss[i].g), 32'(i % 2));
        chk("sat_c0_q", 32'(c0_q), 32'h47);
        chk("sat_c1_q", 32'(c1_q), 32'h87);

        // late arrival while port 0 is in WAIT
        lat = 6;
        @(negedge clk);
        issue_req(0, 1'b0, 17'h00010, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("late_busy", 32'(busy), 32'd1);
        iss.delete();
        issue_req(1, 1'b0, 17'h00020, 8'h00);
        run_until_idle(100);
        chk("late_count", 32'(iss.size()), 32'd1);
        if (iss.size() == 1) begin
            chk("late_g", 32'(iss[0].g), 32'd1);
            chk("late_gap", 32'(iss[0].cyc - ack_cyc[0]), 32'd1);
            chk("late_c1_after", 32'(ack_cyc[1] > iss[0].cyc), 32'd1);
        end
        chk("late_c0_q", 32'(c0_q), 32'h11);
        chk("late_c1_q", 32'(c1_q), 32'h22);

        // reset while a read is outstanding
        lat = 5;
        @(negedge clk);
        issue_req(0, 1'b0, 17'h00010, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("rw_busy", 32'(busy), 32'd1);
        pulse_reset_midcycle("rst2");
        ok = 1;
        repeat (8) begin
            @(negedge clk);
            if (c0_ack !== 1'b0 || c0_q !== 8'h00 || ram_req !== 1'b0) ok = 0;
        end
        chk("rw_abandoned", 32'(ok), 32'd1);
        issue_req(0, 1'b0, 17'h00020, 8'h00);
        run_until_idle(100);
        chk("rw_fresh_q", 32'(c0_q), 32'h22);
        chk("rw_fresh_ack", 32'(c0_ack), 32'd1);

        // table of single transactions
        lat = 2;
        foreach (vt[i]) begin
            iss.delete();
            @(negedge clk);
            issue_req(vt[i].port, vt[i].we, vt[i].a, vt[i].d);
            run_until_idle(100);
            chk($sformatf("tbl%0d_q", i), 32'(get_q(vt[i].port)), 32'(vt[i].exp_q));
            chk($sformatf("tbl%0d_n", i), 32'(iss.size()), 32'd1);
            if (iss.size() == 1) begin
                chk($sformatf("tbl%0d_a", i), 32'(iss[0].a), 32'(vt[i].a));
                chk($sformatf("tbl%0d_we", i), 32'(iss[0].we), 32'(vt[i].we));
                chk($sformatf("tbl%0d_g", i), 32'(iss[0].g), 32'(vt[i].port));
            end
        end

        // randomized traffic, each port in its own address window
        rand_lat = 1'b1;
        sent[0] = 0; sent[1] = 0;
        pend[0] = 0; pend[1] = 0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        pa[0] = c0_ack; pa[1] = c1_ack;
        pr = ram_req;
        ok = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (ram_req != pr) begin
                g = int'(grant);
                chk("rnd_wait", 32'(wait_cnt[g] <= 1), 32'd1);
                pend[g] = 0;
                if (pend[1 - g]) wait_cnt[1 - g]++;
                pr = ram_req;
            end
            for (int p = 0; p < 2; p++) begin
                if (get_ack(p) != pa[p]) begin
                    chk($sformatf("rnd_q%0d", p), 32'(get_q(p)), 32'(exp_q[p]));
                    chk($sformatf("rnd_owner%0d", p), 32'(grant), 32'(p));
                    pa[p] = get_ack(p);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (get_req(p) == get_ack(p) && sent[p] < 40 && $urandom_range(0, 2) == 0) begin
                    ra  = 17'h0C000 + 17'(p * 'h1000) + 17'($urandom_range(0, 63));
                    rwe = 1'($urandom_range(0, 1));
                    rd  = 8'($urandom);
                    if (rwe) begin
                        ref_mem[ra] = rd;
                        exp_q[p] = rd;
                    end else begin
                        exp_q[p] = ref_mem.exists(ra) ? ref_mem[ra] : init_val(ra);
                    end
                    issue_req(p, rwe, ra, rd);
                    sent[p]++;
                    pend[p] = 1;
                    wait_cnt[p] = 0;
                end
            end
            if (sent[0] == 40 && sent[1] == 40 && c0_ack == c0_req && c1_ack == c1_req && !busy) begin
                ok = 1;
                break;
            end
        end
        chk("rnd_done", 32'(ok), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
